mem_port_arbiter: RTL and testbench

Two-requester arbiter for the single 512-bit line port of the DDR2 memory controller. Requester 0 is the boot loader that copies the instruction image into DRAM. Requester 1 is the L2 cache miss/writeback path. The block grants the port to one requester at a time, holds the command until the memory acknowledges it, and returns read data and a one-cycle ready to the granted requester. It replaces the static enable-based mux between loader and L2, and adds a response timeout.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (boot loader, L2), the arbiter and the DDR2 line port.
// The master modport is the arbiter's view; slave is the requester/memory side.
interface mem_port_arbiter_if #(
    parameter int DATA_W  = 512,
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 18
);
    logic               req0_read;
    logic               req0_write;
    logic [INDEX_W-1:0] req0_index;
    logic [TAG_W-1:0]   req0_tag;
    logic [TAG_W-1:0]   req0_write_tag;
    logic [DATA_W-1:0]  req0_write_data;
    logic               req0_ready;
    logic [DATA_W-1:0]  req0_read_data;

    logic               req1_read;
    logic               req1_write;
    logic [INDEX_W-1:0] req1_index;
    logic [TAG_W-1:0]   req1_tag;
    logic [TAG_W-1:0]   req1_write_tag;
    logic [DATA_W-1:0]  req1_write_data;
    logic               req1_ready;
    logic [DATA_W-1:0]  req1_read_data;

    logic               read_L2_MEM;
    logic               write_L2_MEM;
    logic [INDEX_W-1:0] index_L2_MEM;
    logic [TAG_W-1:0]   tag_L2_MEM;
    logic [TAG_W-1:0]   write_tag_L2_MEM;
    logic [DATA_W-1:0]  write_data_L2_MEM;
    logic [DATA_W-1:0]  read_data_MEM_L2;
    logic               ready_MEM_L2;

    modport master (
        input  req0_read, req0_write, req0_index, req0_tag, req0_write_tag, req0_write_data,
        output req0_ready, req0_read_data,
        input  req1_read, req1_write, req1_index, req1_tag, req1_write_tag, req1_write_data,
        output req1_ready, req1_read_data,
        output read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM, write_tag_L2_MEM,
        output write_data_L2_MEM,
        input  read_data_MEM_L2, ready_MEM_L2
    );

    modport slave (
        output req0_read, req0_write, req0_index, req0_tag, req0_write_tag, req0_write_data,
        input  req0_ready, req0_read_data,
        output req1_read, req1_write, req1_index, req1_tag, req1_write_tag, req1_write_data,
        input  req1_ready, req1_read_data,
        input  read_L2_MEM, write_L2_MEM, index_L2_MEM, tag_L2_MEM, write_tag_L2_MEM,
        input  write_data_L2_MEM,
        output read_data_MEM_L2, ready_MEM_L2
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between boot loader (req0) and L2 (req1) for the DDR2 line port.
// Latches the winning command, holds it until memory acknowledges or the response times out.
module mem_port_arbiter #(
    parameter int DATA_W  = 512,
    parameter int INDEX_W = 8,
    parameter int TAG_W   = 18,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               grant,
    output logic               busy,
    output logic               err_timeout
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               last;
    logic               cmd_read;
    logic               cmd_write;
    logic [INDEX_W-1:0] cmd_index;
    logic [TAG_W-1:0]   cmd_tag;
    logic [TAG_W-1:0]   cmd_write_tag;
    logic [DATA_W-1:0]  cmd_write_data;
    logic [DATA_W-1:0]  read_data0;
    logic [DATA_W-1:0]  read_data1;
    logic [CNT_W-1:0]   cnt;

    logic req0_active;
    logic req1_active;
    logic pick1;
    logic timeout_hit;
    logic do_grant;
    logic do_finish;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On a tie the requester not served last wins; last==1 means req1 went last.
    always_comb begin
        req0_active = bus.req0_read | bus.req0_write;
        req1_active = bus.req1_read | bus.req1_write;
        pick1       = req1_active & (~req0_active | ~last);
        timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
        do_grant    = 1'b0;
        do_finish   = 1'b0;
        state_next  = state;
        case (state)
            ST_IDLE: begin
                if (req0_active || req1_active) begin
                    do_grant   = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.ready_MEM_L2 || timeout_hit) begin
                    do_finish  = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant          <= 1'b0;
            last           <= 1'b1;
            cmd_read       <= 1'b0;
            cmd_write      <= 1'b0;
            cmd_index      <= '0;
            cmd_tag        <= '0;
            cmd_write_tag  <= '0;
            cmd_write_data <= '0;
            read_data0     <= '0;
            read_data1     <= '0;
            err_timeout    <= 1'b0;
            cnt            <= '0;
        end else begin
            if (do_grant) begin
                grant          <= pick1;
                last           <= pick1;
                cmd_read       <= pick1 ? bus.req1_read       : bus.req0_read;
                cmd_write      <= pick1 ? bus.req1_write      : bus.req0_write;
                cmd_index      <= pick1 ? bus.req1_index      : bus.req0_index;
                cmd_tag        <= pick1 ? bus.req1_tag        : bus.req0_tag;
                cmd_write_tag  <= pick1 ? bus.req1_write_tag  : bus.req0_write_tag;
                cmd_write_data <= pick1 ? bus.req1_write_data : bus.req0_write_data;
            end
            // A timed-out read hands back an all-zero line.
            if (do_finish) begin
                cnt <= '0;
                if (!bus.ready_MEM_L2) begin
                    err_timeout <= 1'b1;
                end
                if (cmd_read && grant) begin
                    read_data1 <= bus.ready_MEM_L2 ? bus.read_data_MEM_L2 : '0;
                end
                if (cmd_read && !grant) begin
                    read_data0 <= bus.ready_MEM_L2 ? bus.read_data_MEM_L2 : '0;
                end
            end else if (state == ST_WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    assign bus.read_L2_MEM       = (state == ST_WAIT) & cmd_read;
    assign bus.write_L2_MEM      = (state == ST_WAIT) & cmd_write;
    assign bus.index_L2_MEM      = cmd_index;
    assign bus.tag_L2_MEM        = cmd_tag;
    assign bus.write_tag_L2_MEM  = cmd_write_tag;
    assign bus.write_data_L2_MEM = cmd_write_data;
    assign bus.req0_ready        = (state == ST_RESP) & ~grant;
    assign bus.req1_ready        = (state == ST_RESP) & grant;
    assign bus.req0_read_data    = read_data0;
    assign bus.req1_read_data    = read_data1;
    assign busy                  = (state != ST_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table walked in order, plus
// hand sequences for reset values, stray memory ready, reset mid-WAIT and tie-break after reset.
module tb_mem_port_arbiter;
    localparam int DATA_W  = 512;
    localparam int INDEX_W = 8;
    localparam int TAG_W   = 18;
    localparam int TIMEOUT = 16;

    typedef struct {
        logic               rd0;
        logic               wr0;
        logic [INDEX_W-1:0] idx0;
        logic [TAG_W-1:0]   tag0;
        logic               rd1;
        logic               wr1;
        logic [INDEX_W-1:0] idx1;
        logic [TAG_W-1:0]   tag1;
        int                 lat;
        logic               exp_grant;
        logic               exp_rd;
        logic               exp_wr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic grant;
    logic busy;
    logic err_timeout;

    int vectors_applied = 0;
    int miscompares     = 0;
    int txn_id          = 0;
    logic              err_model;
    logic [DATA_W-1:0] rd_model [2];

    mem_port_arbiter_if #(.DATA_W(DATA_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();

    mem_port_arbiter #(
        .DATA_W (DATA_W),
        .INDEX_W(INDEX_W),
        .TAG_W  (TAG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .grant      (grant),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rd0, logic wr0, logic [INDEX_W-1:0] idx0, logic [TAG_W-1:0] tag0,
                                logic rd1, logic wr1, logic [INDEX_W-1:0] idx1, logic [TAG_W-1:0] tag1,
                                int lat, logic g, logic erd, logic ewr);
        vec_t v;
        v.rd0 = rd0; v.wr0 = wr0; v.idx0 = idx0; v.tag0 = tag0;
        v.rd1 = rd1; v.wr1 = wr1; v.idx1 = idx1; v.tag1 = tag1;
        v.lat = lat; v.exp_grant = g; v.exp_rd = erd; v.exp_wr = ewr;
        return v;
    endfunction

    // Distinct 32-bit words per transaction so a wrong or stale line is visible.
    function automatic logic [DATA_W-1:0] pattern(int n);
        logic [DATA_W-1:0] p;
        for (int k = 0; k < DATA_W / 32; k++) begin
            p[k*32 +: 32] = 32'hC0DE_0000 ^ (n << 8) ^ k;
        end
        return p;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic clearRequests();
        bus.req0_read = 1'b0; bus.req0_write = 1'b0; bus.req0_index = '0; bus.req0_tag = '0;
        bus.req0_write_tag = '0; bus.req0_write_data = '0;
        bus.req1_read = 1'b0; bus.req1_write = 1'b0; bus.req1_index = '0; bus.req1_tag = '0;
        bus.req1_write_tag = '0; bus.req1_write_data = '0;
        bus.ready_MEM_L2 = 1'b0; bus.read_data_MEM_L2 = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        bus.req0_read = v.rd0; bus.req0_write = v.wr0; bus.req0_index = v.idx0;
        bus.req0_tag = v.tag0; bus.req0_write_tag = ~v.tag0; bus.req0_write_data = {64{v.idx0}};
        bus.req1_read = v.rd1; bus.req1_write = v.wr1; bus.req1_index = v.idx1;
        bus.req1_tag = v.tag1; bus.req1_write_tag = ~v.tag1; bus.req1_write_data = {64{v.idx1}};
    endtask

    task automatic checkCommand(input vec_t v, input string when);
        logic [INDEX_W-1:0] ei;
        logic [TAG_W-1:0]   et;
        logic [TAG_W-1:0]   ewt;
        ei  = v.exp_grant ? v.idx1 : v.idx0;
        et  = v.exp_grant ? v.tag1 : v.tag0;
        ewt = ~et;
        checkOutput({when, " grant"}, grant, v.exp_grant);
        checkOutput({when, " busy"}, busy, 1'b1);
        checkOutput({when, " read_L2_MEM"}, bus.read_L2_MEM, v.exp_rd);
        checkOutput({when, " write_L2_MEM"}, bus.write_L2_MEM, v.exp_wr);
        checkOutput({when, " index"}, bus.index_L2_MEM, ei);
        checkOutput({when, " tag"}, bus.tag_L2_MEM, et);
        checkOutput({when, " write_tag"}, bus.write_tag_L2_MEM, ewt);
        checkOutput({when, " write_data"}, bus.write_data_L2_MEM, {64{ei}});
        checkOutput({when, " no ready"}, {bus.req0_ready, bus.req1_ready}, 2'b00);
    endtask

    // One full transaction: grant, hold for lat cycles (0 = no response), RESP, back to IDLE.
    task automatic runVector(input vec_t v);
        logic [DATA_W-1:0] pat;
        int                last_cyc;
        logic              g;
        g   = v.exp_grant;
        pat = pattern(txn_id);
        txn_id++;
        applyStimulus(v);
        @(posedge clk); #1;
        checkCommand(v, "wait1");
        bus.read_data_MEM_L2 = pat;
        last_cyc = (v.lat > 0) ? v.lat : TIMEOUT;
        for (int c = 1; c < last_cyc; c++) begin
            @(posedge clk); #1;
        end
        checkCommand(v, "waitlast");
        if (v.lat > 0) bus.ready_MEM_L2 = 1'b1;
        @(posedge clk); #1;
        bus.ready_MEM_L2 = 1'b0;
        if (v.lat == 0) err_model = 1'b1;
        if (v.exp_rd) rd_model[g] = (v.lat > 0) ? pat : '0;
        checkOutput("resp req0_ready", bus.req0_ready, !g);
        checkOutput("resp req1_ready", bus.req1_ready, g);
        checkOutput("resp req0_read_data", bus.req0_read_data, rd_model[0]);
        checkOutput("resp req1_read_data", bus.req1_read_data, rd_model[1]);
        checkOutput("resp strobes", {bus.read_L2_MEM, bus.write_L2_MEM}, 2'b00);
        checkOutput("resp err_timeout", err_timeout, err_model);
        @(posedge clk); #1;
        if (g) begin
            bus.req1_read = 1'b0; bus.req1_write = 1'b0;
        end else begin
            bus.req0_read = 1'b0; bus.req0_write = 1'b0;
        end
        checkOutput("idle busy", busy, 1'b0);
        checkOutput("idle ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    endtask

    vec_t vecs [8];
    vec_t post [3];

    initial begin
        // Main table; req1 field sets repeat where a tie loser keeps requesting.
        vecs[0] = mk(0, 0, 8'h00, 18'h00000, 1, 0, 8'h12, 18'h3ABCD, 3, 1, 1, 0);
        vecs[1] = mk(0, 1, 8'h05, 18'h00005, 0, 0, 8'h00, 18'h00000, 2, 0, 0, 1);
        vecs[2] = mk(1, 0, 8'h20, 18'h00100, 1, 0, 8'h21, 18'h00101, 1, 1, 1, 0);
        vecs[3] = mk(1, 0, 8'h20, 18'h00100, 0, 0, 8'h00, 18'h00000, 1, 0, 1, 0);
        vecs[4] = mk(0, 0, 8'h00, 18'h00000, 1, 1, 8'h33, 18'h2AAAA, 4, 1, 1, 1);
        vecs[5] = mk(0, 1, 8'h40, 18'h12345, 1, 0, 8'h41, 18'h00041, 2, 0, 0, 1);
        vecs[6] = mk(0, 0, 8'h00, 18'h00000, 1, 0, 8'h41, 18'h00041, 0, 1, 1, 0);
        vecs[7] = mk(1, 0, 8'h50, 18'h3FFFF, 0, 0, 8'h00, 18'h00000, 2, 0, 1, 0);
        post[0] = mk(1, 0, 8'h60, 18'h00060, 1, 0, 8'h61, 18'h00061, 1, 0, 1, 0);
        post[1] = mk(0, 0, 8'h00, 18'h00000, 1, 0, 8'h61, 18'h00061, 1, 1, 1, 0);
        post[2] = mk(1, 0, 8'h70, 18'h00070, 1, 0, 8'h71, 18'h00071, 2, 0, 1, 0);

        rst = 1'b1;
        clearRequests();
        err_model = 1'b0;
        rd_model[0] = '0;
        rd_model[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset grant", grant, 1'b0);
        checkOutput("reset err_timeout", err_timeout, 1'b0);
        checkOutput("reset strobes", {bus.read_L2_MEM, bus.write_L2_MEM}, 2'b00);
        checkOutput("reset ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        checkOutput("reset index", bus.index_L2_MEM, '0);
        checkOutput("reset req0_read_data", bus.req0_read_data, '0);
        checkOutput("reset req1_read_data", bus.req1_read_data, '0);
        @(negedge clk);
        rst = 1'b0;

        // A memory ready while idle must not start or complete anything.
        @(negedge clk);
        bus.ready_MEM_L2 = 1'b1;
        bus.read_data_MEM_L2 = pattern(99);
        @(posedge clk); #1;
        bus.ready_MEM_L2 = 1'b0;
        checkOutput("stray ready busy", busy, 1'b0);
        checkOutput("stray ready out", {bus.req0_ready, bus.req1_ready}, 2'b00);
        checkOutput("stray ready data", bus.req1_read_data, '0);

        for (int i = 0; i < 8; i++) begin
            runVector(vecs[i]);
        end

        // Reset in the second WAIT cycle abandons the transaction at once.
        @(negedge clk);
        bus.req1_read = 1'b1;
        bus.req1_index = 8'h61;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("wait2 read_L2_MEM", bus.read_L2_MEM, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midreset read_L2_MEM", bus.read_L2_MEM, 1'b0);
        checkOutput("midreset busy", busy, 1'b0);
        checkOutput("midreset ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
        checkOutput("midreset grant", grant, 1'b0);
        checkOutput("midreset err_timeout", err_timeout, 1'b0);
        checkOutput("midreset req1_read_data", bus.req1_read_data, '0);
        clearRequests();
        err_model = 1'b0;
        rd_model[0] = '0;
        rd_model[1] = '0;
        @(negedge clk);
        rst = 1'b0;

        // After reset: tie goes to req0, then req1, then req0 wins the next tie.
        for (int i = 0; i < 3; i++) begin
            runVector(post[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end
endmodule
